// File: rtl/segment_ex_mem_elastic_if.sv
// EX->MEM handshake bundle for segment_ex_mem_elastic.
// The forwarding taps exist only when EX_MEM_FWD_EN is defined.
interface segment_ex_mem_elastic_if #(
    parameter int DATA_W = 21,
    parameter int REG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              MemToReg_in;
    logic              MemRead_in;
    logic              MemWrite_in;
    logic              RegWrite_in;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] RD3_in;
    logic [REG_W-1:0]  RR3_in;

    logic              out_valid;
    logic              out_ready;
    logic              MemToReg_out;
    logic              MemRead_out;
    logic              MemWrite_out;
    logic              RegWrite_out;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] RD3_out;
    logic [REG_W-1:0]  RR3_out;
    logic [1:0]        occupancy;
`ifdef EX_MEM_FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rr3;
    logic [DATA_W-1:0] fwd_alu;
`endif

    modport master (
        output in_valid, MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in,
               alu_in, RD3_in, RR3_in, out_ready,
        input  in_ready, out_valid, MemToReg_out, MemRead_out, MemWrite_out,
               RegWrite_out, alu_out, RD3_out, RR3_out, occupancy
`ifdef EX_MEM_FWD_EN
        , input fwd_valid, fwd_rr3, fwd_alu
`endif
    );

    modport slave (
        input  in_valid, MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in,
               alu_in, RD3_in, RR3_in, out_ready,
        output in_ready, out_valid, MemToReg_out, MemRead_out, MemWrite_out,
               RegWrite_out, alu_out, RD3_out, RR3_out, occupancy
`ifdef EX_MEM_FWD_EN
        , output fwd_valid, fwd_rr3, fwd_alu
`endif
    );
endinterface

// File: rtl/segment_ex_mem_elastic.sv
// Two-entry elastic (main + skid) EX/MEM pipeline register with flush.
// Optional EX-stage forwarding taps when EX_MEM_FWD_EN is defined.
module segment_ex_mem_elastic #(
    parameter int DATA_W = 21,
    parameter int REG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    segment_ex_mem_elastic_if.slave  bus
);
    localparam int BW = 4 + 2 * DATA_W + REG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   main_q, main_d;
    logic [BW-1:0]   skid_q, skid_d;
    logic [BW-1:0]   in_bundle_s;
    logic [3:0]      main_ctrl_s;
    logic            out_valid_s;
    logic            accept_s;
    logic            deliver_s;

    assign in_bundle_s = {bus.MemToReg_in, bus.MemRead_in, bus.MemWrite_in, bus.RegWrite_in,
                          bus.alu_in, bus.RD3_in, bus.RR3_in};

    // in_ready depends only on registered state so no combinational path from out_ready.
    assign bus.in_ready = (state_q != FULL) & ~rst;
    assign out_valid_s  = (state_q != EMPTY);
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign deliver_s    = out_valid_s & bus.out_ready;

    // Next-state and entry update; flush overrides both accept and deliver.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        state_d = ONE;
                        main_d  = in_bundle_s;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && deliver_s) begin
                        main_d = in_bundle_s;
                    end else if (accept_s) begin
                        state_d = FULL;
                        skid_d  = in_bundle_s;
                    end else if (deliver_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                FULL: begin
                    if (deliver_s) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= {BW{1'b0}};
            skid_q  <= {BW{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign {main_ctrl_s, bus.alu_out, bus.RD3_out, bus.RR3_out} = main_q;

    // Control bits are qualified by out_valid so a stale main entry never fires a memory op.
    assign bus.MemToReg_out = main_ctrl_s[3] & out_valid_s;
    assign bus.MemRead_out  = main_ctrl_s[2] & out_valid_s;
    assign bus.MemWrite_out = main_ctrl_s[1] & out_valid_s;
    assign bus.RegWrite_out = main_ctrl_s[0] & out_valid_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.occupancy    = state_q;

`ifdef EX_MEM_FWD_EN
    assign bus.fwd_valid = out_valid_s & main_ctrl_s[0] & (bus.RR3_out != {REG_W{1'b0}});
    assign bus.fwd_rr3   = bus.RR3_out;
    assign bus.fwd_alu   = bus.alu_out;
`endif
endmodule

// File: doc/segment_ex_mem_elastic.md
SEGMENT_EX_MEM_ELASTIC -- requirements
Module: segment_ex_mem_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 21, width of ALU result and store-data fields.
REQ-002 SHALL have parameter REG_W, default 4, width of destination register index.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port in_valid  input  1  EX stage presents a bundle.
REQ-007 SHALL have port in_ready  output  1  stage can accept a bundle this cycle.
REQ-008 SHALL have ports MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in  input  1 each  EX control bits.
REQ-009 SHALL have ports alu_in, RD3_in  input  DATA_W each  ALU result, store data.
REQ-010 SHALL have port RR3_in  input  REG_W  destination register index.
REQ-011 SHALL have port out_valid  output  1  MEM stage bundle valid.
REQ-012 SHALL have port out_ready  input  1  MEM stage consumes the bundle.
REQ-013 SHALL have ports MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out  output  1 each.
REQ-014 SHALL have ports alu_out, RD3_out  output  DATA_W each; RR3_out  output  REG_W.
REQ-015 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-016 SHALL hold two entries: main (drives outputs) and skid; states EMPTY, ONE, FULL; occupancy = 0/1/2.
REQ-017 SHALL define accept = in_valid & in_ready, deliver = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (state != FULL) & !rst, combinationally from registered state only (no path from out_ready).
REQ-019 SHALL drive out_valid = (state != EMPTY).
REQ-020 SHALL give 1-cycle latency: bundle accepted at edge k is on outputs with out_valid=1 after edge k when state was EMPTY.
REQ-021 Transitions: EMPTY+accept -> ONE (main<=in); ONE+accept, no deliver -> FULL (skid<=in); ONE+accept+deliver -> ONE (main<=in); ONE+deliver only -> EMPTY; FULL+deliver -> ONE (main<=skid); otherwise hold.
REQ-022 SHALL preserve strict FIFO order; no bundle duplicated or dropped except by flush/reset.
REQ-023 SHALL gate MemToReg_out, MemRead_out, MemWrite_out, RegWrite_out to 0 whenever out_valid=0; data outputs hold last main value.
REQ-024 Flush SHALL have priority over accept and deliver: next state EMPTY, both entries invalidated, same-cycle input discarded.
REQ-025 SHALL hold main contents stable while out_valid=1 and out_ready=0.

Reset
REQ-026 rst=1 SHALL immediately, without clock, force state EMPTY, occupancy 0, out_valid 0, in_ready 0, all control outputs 0, alu_out/RD3_out/RR3_out 0.
REQ-027 Reset asserted mid-operation SHALL discard both entries; first edge after deassertion behaves as from EMPTY.

Configuration
REQ-028 Macro EX_MEM_FWD_EN, when defined, SHALL add outputs fwd_valid (1), fwd_rr3 (REG_W), fwd_alu (DATA_W) = out_valid & RegWrite_out & (RR3_out != 0), RR3_out, alu_out, for EX-stage forwarding; reset value 0.
REQ-029 Without EX_MEM_FWD_EN those ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset: rst=1 with in_valid=1, alu_in=100 -> all outputs 0, in_ready=0, occupancy 0; release rst -> in_ready=1.
REQ-031 Pass-through: out_ready=1, accept {MemToReg=1, MemRead=1, RegWrite=1, alu=100, RD3=200, RR3=5} -> next cycle out_valid=1 with those values, occupancy 1.
REQ-032 Backpressure: out_ready=0, push alu=300 then 400 -> occupancy 2, in_ready=0, outputs hold 300; raise out_ready -> 300 then 400 delivered in order, occupancy 2->1->0.
REQ-033 Flush: state FULL, flush=1 with in_valid=1 alu=500 -> next cycle occupancy 0, out_valid=0, MemWrite_out=0, 500 never appears.
REQ-034 Simultaneous: state ONE (alu=10), accept alu=20 with out_ready=1 -> next cycle occupancy 1, alu_out=20.
REQ-035 EX_MEM_FWD_EN defined: output bundle RegWrite=1, RR3=6, alu=300 -> fwd_valid=1, fwd_rr3=6, fwd_alu=300; RR3=0 -> fwd_valid=0.
